m_ifetch: RTL and testbench

M_IFETCH -- requirements
Module: m_ifetch

---
 rtl/cpu_pkg.sv | 17 +
 rtl/m_ifetch_fifo.sv | 56 +++++
 rtl/m_ifetch.sv | 103 ++++++++++
 tb/tb_m_ifetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding and fetch defaults.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
    localparam int FETCH_DEPTH_DEFAULT = 2;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/m_ifetch_fifo.sv
// Prefetch buffer: DEPTH x {pc, word} FIFO with flush.
module m_ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   entry,
    output logic [63:0]   head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    // A full buffer still accepts a push when the head leaves this cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/m_ifetch.sv
// Instruction fetch: one outstanding memory request, credit-checked
// against a small prefetch buffer, with redirect flush and drop.
module m_ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic        w_imem_ack,
    input  logic [31:0] w_imem_data,
    output logic        w_inst_valid,
    output logic [31:0] w_inst,
    output logic [31:0] w_inst_pc,
    input  logic        w_inst_ready,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic [31:0]   pc;
    logic [31:0]   pc_n;
    logic [31:0]   addr;
    logic [31:0]   addr_n;
    logic [CW-1:0] count;
    logic [CW-1:0] occ_n;
    logic [63:0]   head;
    logic          kept;
    logic          pop;
    logic          room;

    assign w_imem_req   = (state != S_IDLE);
    assign w_imem_addr  = addr;
    assign w_inst_valid = (count != '0);
    assign w_inst_pc    = head[63:32];
    assign w_inst       = head[31:0];

    // Redirect wins over both push and pop.
    assign kept  = w_imem_req && w_imem_ack && (state == S_REQ)
                   && !w_redirect;
    assign pop   = w_inst_valid && w_inst_ready && !w_redirect;
    assign occ_n = w_redirect ? '0 : count + CW'(kept) - CW'(pop);
    assign room  = occ_n < CW'(DEPTH);

    // pc is the next address to request; it equals addr while in REQ.
    assign pc_n = w_redirect ? word_align(w_redirect_pc)
                : kept       ? addr + 32'd4
                :              pc;

    always_comb begin
        state_n = state;
        addr_n  = addr;
        unique case (state)
            S_IDLE: begin
                if (room) begin
                    state_n = S_REQ;
                    addr_n  = pc_n;
                end
            end
            S_REQ, S_DROP: begin
                if (w_imem_ack) begin
                    state_n = room ? S_REQ : S_IDLE;
                    addr_n  = pc_n;
                end else if (w_redirect) begin
                    state_n = S_DROP;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            addr  <= addr_n;
        end
    end

    m_ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .push  (kept),
        .pop   (pop),
        .flush (w_redirect),
        .entry ({addr, w_imem_data}),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_m_ifetch.sv
// Bench for m_ifetch: directed literal cases plus randomized run
// checked every cycle against a queue-based fetch model.
module tb_m_ifetch;

    localparam int DEPTH = 2;

    logic        w_clk;
    logic        w_rst_n;
    logic        w_imem_ack;
    logic        w_inst_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        req2;
    logic [31:0] addr2;
    logic [31:0] data2;
    logic        valid2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;

    int checks = 0;
    int passed = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign data  = mem_f(addr);
    assign data2 = mem_f(addr2);

    m_ifetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_imem_req    (req),
        .w_imem_addr   (addr),
        .w_imem_ack    (w_imem_ack),
        .w_imem_data   (data),
        .w_inst_valid  (valid),
        .w_inst        (inst),
        .w_inst_pc     (inst_pc),
        .w_inst_ready  (w_inst_ready),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc)
    );

    m_ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_imem_req    (req2),
        .w_imem_addr   (addr2),
        .w_imem_ack    (w_imem_ack),
        .w_imem_data   (data2),
        .w_inst_valid  (valid2),
        .w_inst        (inst2),
        .w_inst_pc     (inst_pc2),
        .w_inst_ready  (w_inst_ready),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h at %0t",
                      name, act, exp, $time);
    endfunction

    // Reference model: queue of buffered {pc, word}, next fetch PC,
    // and whether the outstanding response must be thrown away.
    logic [63:0] q[$];
    logic [31:0] exp_pc;
    logic        drop;
    logic        live = 1'b0;
    logic        p_rst = 1'b0;
    logic        p_req = 1'b0;
    logic        p_done = 1'b0;
    logic [31:0] p_addr = '0;

    always @(negedge w_clk) begin
        if (live) begin
            if (!p_rst) begin
                chk("rst_req", req, 0);
                chk("rst_valid", valid, 0);
            end else begin
                if (p_req && !p_done) begin
                    chk("hold_req", req, 1);
                    chk("hold_addr", addr, p_addr);
                end else begin
                    chk("issue_req", req, q.size() < DEPTH);
                    if (req) chk("issue_addr", addr, exp_pc);
                end
                chk("valid", valid, q.size() != 0);
                if (q.size() != 0 && valid) begin
                    chk("inst_pc", inst_pc, q[0][63:32]);
                    chk("inst", inst, q[0][31:0]);
                end
            end
        end
        if (!w_rst_n) begin
            q.delete();
            exp_pc = 32'h0;
            drop = 1'b0;
            live = 1'b1;
        end else if (live) begin
            if (w_redirect) begin
                q.delete();
                exp_pc = {w_redirect_pc[31:2], 2'b00};
                drop = req && !w_imem_ack;
            end else begin
                if (q.size() != 0 && w_inst_ready) void'(q.pop_front());
                if (req && w_imem_ack) begin
                    if (drop) begin
                        drop = 1'b0;
                    end else begin
                        q.push_back({addr, mem_f(addr)});
                        exp_pc = addr + 32'd4;
                    end
                end
            end
        end
        p_rst = w_rst_n;
        p_req = req;
        p_done = req && w_imem_ack;
        p_addr = addr;
    end

    task automatic step(input logic ack, input logic rdy,
                        input logic rdir, input logic [31:0] rpc);
        @(posedge w_clk);
        #1;
        w_imem_ack = ack;
        w_inst_ready = rdy;
        w_redirect = rdir;
        w_redirect_pc = rpc;
        @(negedge w_clk);
    endtask

    task automatic do_reset();
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b0;
        repeat (2) @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        @(negedge w_clk);
        chk("rel_req", req, 0);
        chk("rel_valid", valid, 0);
    endtask

    initial begin
        w_rst_n = 1'b0;
        w_imem_ack = 1'b1;
        w_inst_ready = 1'b1;
        w_redirect = 1'b0;
        w_redirect_pc = '0;

        // Streaming: one fetch per cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            chk("a_req", req, 1);
            chk("a_addr", addr, 32'(4 * i));
            if (i > 0) chk("a_pc", inst_pc, 32'(4 * (i - 1)));
        end

        // Stalled decode: buffer fills to DEPTH, then waits for a pop.
        w_inst_ready = 1'b0;
        do_reset();
        step(1, 0, 0, 0);
        chk("b_addr0", addr, 32'h0);
        step(1, 0, 0, 0);
        chk("b_addr4", addr, 32'h4);
        step(1, 0, 0, 0);
        chk("b_full_req", req, 0);
        chk("b_head", inst_pc, 32'h0);
        step(1, 0, 0, 0);
        chk("b_full_req2", req, 0);
        step(1, 1, 0, 0);
        chk("b_pop_req", req, 0);
        step(1, 0, 0, 0);
        chk("b_req8", req, 1);
        chk("b_addr8", addr, 32'h8);
        chk("b_head4", inst_pc, 32'h4);

        // Late ack at address 4.
        do_reset();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("c_addr_w1", addr, 32'h4);
        step(0, 1, 0, 0);
        chk("c_addr_w2", addr, 32'h4);
        chk("c_empty", valid, 0);
        step(0, 1, 0, 0);
        chk("c_addr_w3", addr, 32'h4);
        step(1, 1, 0, 0);
        chk("c_addr_w4", addr, 32'h4);
        chk("c_req_w4", req, 1);
        step(0, 1, 0, 0);
        chk("c_pc4", inst_pc, 32'h4);
        chk("c_addr8", addr, 32'h8);
        step(0, 1, 0, 0);
        chk("c_single", valid, 0);

        // Redirect while waiting: drop the late response.
        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h40);
        chk("d_addr8", addr, 32'h8);
        step(0, 1, 0, 0);
        chk("d_drop_addr", addr, 32'h8);
        chk("d_flushed", valid, 0);
        step(1, 1, 0, 0);
        chk("d_drop_ack", addr, 32'h8);
        step(1, 1, 0, 0);
        chk("d_new_addr", addr, 32'h40);
        chk("d_no_stale", valid, 0);
        step(1, 1, 0, 0);
        chk("d_first_pc", inst_pc, 32'h40);

        // Redirect together with push, pop and ack.
        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h103);
        chk("e_addr8", addr, 32'h8);
        step(0, 1, 0, 0);
        chk("e_empty", valid, 0);
        chk("e_addr", addr, 32'h100);

        // Wrap-around and reset mid-transfer on the high-PC instance.
        do_reset();
        chk("f_req0", req2, 0);
        step(1, 1, 0, 0);
        chk("f_addr0", addr2, 32'hFFFF_FFF8);
        step(1, 1, 0, 0);
        chk("f_addr1", addr2, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        chk("f_wrap", addr2, 32'h0);
        chk("f_pc", inst_pc2, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b0;
        @(posedge w_clk);
        #1;
        w_imem_ack = 1'b1;
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        @(negedge w_clk);
        chk("f_rst_req", req2, 0);
        chk("f_rst_valid", valid2, 0);
        step(1, 1, 0, 0);
        chk("f_req_rpc", req2, 1);
        chk("f_addr_rpc", addr2, 32'hFFFF_FFF8);
        chk("f_no_stale", valid2, 0);
        step(1, 1, 0, 0);
        chk("f_first_pc", inst_pc2, 32'hFFFF_FFF8);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            @(posedge w_clk);
            #1;
            w_rst_n = ($urandom_range(0, 299) != 0);
            w_imem_ack = ($urandom_range(0, 99) < 55);
            w_inst_ready = ($urandom_range(0, 99) < ((i < 2500) ? 70 : 30));
            w_redirect = ($urandom_range(0, 99) < 6);
            w_redirect_pc = $urandom;
        end
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        w_redirect = 1'b0;
        repeat (4) @(negedge w_clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
